// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between writeback and a parked long-latency result.
// Optional statistics counters are enabled with `define REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter #(
  parameter int SIZE         = 32,
  parameter int AMOUNT_REG   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WB_WE,
  input  logic [AMOUNT_REG-1:0] WB_ADDR,
  input  logic [SIZE-1:0]       WB_DATA,
  output logic                  STALL_WB,
  input  logic                  LU_VALID,
  output logic                  LU_READY,
  input  logic [AMOUNT_REG-1:0] LU_ADDR,
  input  logic [SIZE-1:0]       LU_DATA,
  output logic                  WE3,
  output logic [AMOUNT_REG-1:0] RA3,
  output logic [SIZE-1:0]       WD3,
  output logic                  PEND_VALID,
  output logic [AMOUNT_REG-1:0] PEND_ADDR,
  output logic                  ERR_R15,
  input  logic                  ERR_CLR,
  output logic [15:0]           STAT_LU_WR,
  output logic [15:0]           STAT_STALL
);

  typedef enum logic {EMPTY = 1'b0, PEND = 1'b1} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  function automatic logic is_r15(input logic [AMOUNT_REG-1:0] addr);
    return addr == {AMOUNT_REG{1'b1}};
  endfunction

  state_t                state_r, state_nxt_s;
  logic [3:0]            starve_r, starve_nxt_s;
  logic [AMOUNT_REG-1:0] pend_addr_r;
  logic [SIZE-1:0]       pend_data_r;
  logic                  lu_ready_r;
  logic                  err_r;
  logic                  pend_s, wb_req_s;
  logic                  grant_lu_s, grant_wb_s, stall_s, err_set_s;
  logic                  we_s;
  logic [AMOUNT_REG-1:0] ra_s;
  logic [SIZE-1:0]       wd_s;

  // Arbitration between the parked entry and writeback (R15 writeback is simply ignored).
  always_comb begin
    pend_s     = (state_r == PEND);
    wb_req_s   = WB_WE && !is_r15(WB_ADDR);
    grant_lu_s = 1'b0;
    grant_wb_s = 1'b0;
    stall_s    = 1'b0;
    if (pend_s) begin
      if (!wb_req_s) begin
        grant_lu_s = 1'b1;
      end else if ((WB_ADDR == pend_addr_r) || (starve_r == STARVE_MAX)) begin
        grant_lu_s = 1'b1;
        stall_s    = 1'b1;
      end else begin
        grant_wb_s = 1'b1;
      end
    end else begin
      grant_wb_s = wb_req_s;
    end
    err_set_s = grant_lu_s && is_r15(pend_addr_r);
  end

  // Write-port mux; a parked R15 entry is consumed without a write.
  always_comb begin
    we_s = 1'b0;
    ra_s = {AMOUNT_REG{1'b0}};
    wd_s = {SIZE{1'b0}};
    if (!RST_N) begin
      we_s = 1'b0;
    end else if (grant_lu_s && !is_r15(pend_addr_r)) begin
      we_s = 1'b1;
      ra_s = pend_addr_r;
      wd_s = pend_data_r;
    end else if (grant_wb_s) begin
      we_s = 1'b1;
      ra_s = WB_ADDR;
      wd_s = WB_DATA;
    end else begin
      we_s = 1'b0;
    end
  end

  // Next-state and starve-counter logic.
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_r;
    case (state_r)
      EMPTY: begin
        starve_nxt_s = 4'd0;
        if (LU_VALID) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      PEND: begin
        if (grant_lu_s) begin
          state_nxt_s  = EMPTY;
          starve_nxt_s = 4'd0;
        end else if (grant_wb_s && (starve_r != STARVE_MAX)) begin
          starve_nxt_s = starve_r + 4'd1;
        end else begin
          starve_nxt_s = starve_r;
        end
      end
      default: begin
        state_nxt_s  = EMPTY;
        starve_nxt_s = 4'd0;
      end
    endcase
  end

  // State, holding register and ready flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= EMPTY;
      starve_r    <= 4'd0;
      pend_addr_r <= {AMOUNT_REG{1'b0}};
      pend_data_r <= {SIZE{1'b0}};
      lu_ready_r  <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      starve_r   <= starve_nxt_s;
      lu_ready_r <= (state_nxt_s == EMPTY);
      if ((state_r == EMPTY) && LU_VALID) begin
        pend_addr_r <= LU_ADDR;
        pend_data_r <= LU_DATA;
      end else begin
        pend_addr_r <= pend_addr_r;
        pend_data_r <= pend_data_r;
      end
    end
  end

  // Sticky R15 error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else if (ERR_CLR) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_lu_wr_r, stat_stall_r;

  // Free-running statistics counters, wrapping naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_lu_wr_r <= 16'd0;
      stat_stall_r <= 16'd0;
    end else begin
      if (grant_lu_s && !is_r15(pend_addr_r)) begin
        stat_lu_wr_r <= stat_lu_wr_r + 16'd1;
      end else begin
        stat_lu_wr_r <= stat_lu_wr_r;
      end
      if (stall_s) begin
        stat_stall_r <= stat_stall_r + 16'd1;
      end else begin
        stat_stall_r <= stat_stall_r;
      end
    end
  end

  assign STAT_LU_WR = stat_lu_wr_r;
  assign STAT_STALL = stat_stall_r;
`else
  assign STAT_LU_WR = 16'd0;
  assign STAT_STALL = 16'd0;
`endif

  assign WE3        = we_s;
  assign RA3        = ra_s;
  assign WD3        = wd_s;
  assign STALL_WB   = stall_s;
  assign LU_READY   = lu_ready_r;
  assign PEND_VALID = pend_s;
  assign PEND_ADDR  = pend_s ? pend_addr_r : {AMOUNT_REG{1'b0}};
  assign ERR_R15    = err_r;

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (WE3/RA3/WD3) between two requesters: the pipeline writeback stage and a long-latency unit such as a load-return or multi-cycle ALU.
- Long-latency results are parked in a one-entry holding register and inserted into idle writeback slots.
- The writeback stage is stalled when the parked entry starves or when both requesters target the same register.
- Blocks all writes to R15, which is owned by the PC path.

Parameters:
SIZE, 32, data width of a register
AMOUNT_REG, 4, register address width
STARVE_LIMIT, 4, cycles a parked entry may lose arbitration before writeback is stalled (1..15)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
WB_WE  in  1  writeback requests a write this cycle
WB_ADDR  in  AMOUNT_REG  writeback destination
WB_DATA  in  SIZE  writeback data
STALL_WB  out  1  writeback not granted; pipeline must hold WB_* stable
LU_VALID  in  1  long-latency result valid
LU_READY  out  1  holding register can accept
LU_ADDR  in  AMOUNT_REG  long-latency destination
LU_DATA  in  SIZE  long-latency data
WE3  out  1  register file write enable
RA3  out  AMOUNT_REG  register file write address
WD3  out  SIZE  register file write data
PEND_VALID  out  1  holding register occupied (for hazard detection)
PEND_ADDR  out  AMOUNT_REG  destination of the parked entry
ERR_R15  out  1  sticky flag: a long-latency write to R15 was dropped
ERR_CLR  in  1  synchronous clear of ERR_R15
STAT_LU_WR  out  16  granted long-latency writes (optional feature)
STAT_STALL  out  16  STALL_WB cycles (optional feature)

Behaviour:

Reset:
- RST_N low asynchronously sets the state to EMPTY, the starve counter to 0, ERR_R15 to 0, and the statistics counters to 0.
- WE3, STALL_WB and PEND_VALID are 0 while reset is held. PEND_ADDR reads 0.
- A reset mid-operation discards any parked entry; it is never written.

State machine:
- EMPTY: LU_READY=1. When LU_VALID and LU_READY at a rising edge, capture LU_ADDR/LU_DATA and go to PEND.
- PEND: LU_READY=0. When the parked entry is granted, return to EMPTY at the next edge.
- There is no same-cycle refill: LU_READY is registered and depends only on state.

Write port:
- WE3/RA3/WD3 are combinational from the grant mux, so the register file write lands at the same edge.
- Long-latency latency: accepted at edge N, earliest write at edge N+1.

Arbitration, evaluated every cycle:
- Only WB_WE: grant WB.
- Only PEND: grant parked entry.
- Both, WB_ADDR equals PEND_ADDR: grant parked entry and assert STALL_WB. WB then writes next cycle, so the newer value lands last.
- Both, starve counter equals STARVE_LIMIT: grant parked entry and assert STALL_WB.
- Both otherwise: grant WB; starve counter increments, saturating at STARVE_LIMIT.
- Starve counter clears whenever the state is EMPTY.

R15 handling:
- Address all-ones is never driven with WE3=1.
- WB write to R15: silently ignored, no stall.
- Long-latency write to R15: accepted, then discarded at grant time (no WE3). ERR_R15 sets.

ERR_R15:
- Sticky until ERR_CLR.
- If set and clear happen in the same cycle, the set wins.

Idle cycles: when nothing is granted, WE3=0 and RA3/WD3 are 0.

Optional Feature:
REGFILE_ARB_STATS_EN
- Defined: STAT_LU_WR increments on each granted non-R15 long-latency write. STAT_STALL increments each cycle STALL_WB=1. Both wrap at 16'hFFFF -> 0 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset, then WB_WE=1, WB_ADDR=3, WB_DATA=32'hA5 for one cycle -> same cycle WE3=1, RA3=3, WD3=32'hA5, STALL_WB=0.
- LU_VALID=1, LU_ADDR=5, LU_DATA=32'h11 with WB idle -> PEND_VALID=1 and LU_READY=0 next cycle; write R5=32'h11 the cycle after; then EMPTY.
- Parked entry to R6 and WB_WE held on R2 continuously, STARVE_LIMIT=4 -> WB granted 4 cycles; cycle 5 has STALL_WB=1 and R6 written; WB resumes next cycle.
- Parked entry to R7 and WB write to R7 in the same cycle -> parked value written first with STALL_WB=1; WB value written next cycle; final R7 equals WB_DATA.
- LU write to address 4'hF -> WE3 stays 0 throughout; ERR_R15=1 and stays set; ERR_CLR pulse clears it.
- Assert RST_N=0 while PEND with WB_WE=1 -> WE3, STALL_WB and PEND_VALID drop immediately; after release LU_READY=1 and the parked data is never written.
